dmem_responder: RTL and testbench

- Data-memory responder on the core's load/store port.
- Accepts the core's word address, lane-aligned store data and 4-bit byte write-enable every cycle.
- Returns read data one cycle later, which matches the core's one-cycle delayed-load timing.
- Also hosts a small MMIO window: a free-running 64-bit cycle timer and a tohost/halt register for simulation and test exit.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store port between the core and the data-memory responder.
// The core drives the request side; the responder returns registered data and status.
interface dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        halt;
  logic [30:0] exit_code;
  logic        err;

  modport master (
    output addr, wdata, we,
    input  rdata, halt, exit_code, err
  );

  modport slave (
    input  addr, wdata, we,
    output rdata, halt, exit_code, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane writes, one-cycle read latency,
// plus a 16-byte MMIO window holding a 64-bit cycle timer and the tohost/halt register.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] SEL_MTIME_LO = 2'd0;
  localparam logic [1:0] SEL_MTIME_HI = 2'd1;
  localparam logic [1:0] SEL_TOHOST   = 2'd2;

  logic             ram_hit_c;
  logic             mmio_hit_c;
  logic             unmapped_c;
  logic             wr_c;
  logic [IDX_W-1:0] idx_c;
  logic [1:0]       sel_c;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [63:0] mtime_q,  mtime_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        halt_q,   halt_d;
  logic        err_q,    err_d;

  // Replace the byte lanes of old_w selected by be with the matching lanes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode; RAM takes priority should the windows ever overlap.
  always_comb begin
    ram_hit_c  = {1'b0, bus.addr} < RAM_BYTES;
    mmio_hit_c = !ram_hit_c && (bus.addr[31:4] == MMIO_BASE[31:4]);
    unmapped_c = !ram_hit_c && !mmio_hit_c;
    wr_c       = |bus.we;
    idx_c      = bus.addr[IDX_W+1:2];
    sel_c      = bus.addr[3:2];
  end

  // Next-state for read data, timer, tohost, halt and err.
  always_comb begin
    mtime_d  = mtime_q + 64'd1;
    tohost_d = tohost_q;
    halt_d   = halt_q;
    err_d    = wr_c && unmapped_c;
    rdata_d  = '0;

    if (ram_hit_c) begin
      rdata_d = mem_q[idx_c];
    end else if (mmio_hit_c) begin
      case (sel_c)
        SEL_MTIME_LO: rdata_d = mtime_q[31:0];
        SEL_MTIME_HI: rdata_d = mtime_q[63:32];
        SEL_TOHOST:   rdata_d = tohost_q;
        default:      rdata_d = '0;
      endcase
    end

    // A timer write freezes the whole counter for that cycle.
    if (mmio_hit_c && wr_c) begin
      case (sel_c)
        SEL_MTIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.wdata, bus.we)};
        SEL_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], bus.wdata, bus.we), mtime_q[31:0]};
        SEL_TOHOST: begin
          tohost_d = merge_bytes(tohost_q, bus.wdata, bus.we);
          if (bus.we == 4'hF && bus.wdata[0]) halt_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= '0;
      tohost_q <= '0;
      rdata_q  <= '0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      tohost_q <= tohost_d;
      rdata_q  <= rdata_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

  // RAM contents survive reset; writes are simply blocked while it is asserted.
  always_ff @(posedge clk) begin
    if (!rst && ram_hit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.we[i]) mem_q[idx_c][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.halt      = halt_q;
  assign bus.exit_code = tohost_q[31:1];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, read-first, timer, tohost exit,
// unmapped writes and reset behaviour, all with hand-computed expectations.
module tb_dmem_responder;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [31:0] UNMAPPED  = 32'h0000_1000;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  dmem_responder_if bus_if ();

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request, let one rising edge pass, then settle away from the edge.
  task automatic step(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bus_if.addr  = a;
    bus_if.we    = w;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus_if.addr  = MMIO_BASE;
    bus_if.we    = 4'h0;
    bus_if.wdata = 32'h0;

    // Reset state
    step(MMIO_BASE, 4'h0, 32'h0);
    check("rst_rdata", bus_if.rdata, 32'h0);
    check("rst_halt", 32'(bus_if.halt), 32'h0);
    check("rst_err", 32'(bus_if.err), 32'h0);
    check("rst_exit", 32'(bus_if.exit_code), 32'h0);
    rst = 1'b0;

    // Timer counts 0,1,2,3,4 from reset
    for (int i = 0; i < 5; i++) begin
      step(MMIO_BASE, 4'h0, 32'h0);
      check($sformatf("mtime_%0d", i), bus_if.rdata, 32'(i));
    end

    // Byte lanes and read-first on a partial write
    step(32'h10, 4'hF, 32'hDEAD_BEEF);
    step(32'h10, 4'b0010, 32'h0000_5500);
    check("lane_rd_first", bus_if.rdata, 32'hDEAD_BEEF);
    step(32'h10, 4'h0, 32'h0);
    check("lane_merge", bus_if.rdata, 32'hDEAD_55EF);

    // Read-first and read-after-write on a full word
    step(32'h20, 4'hF, 32'h0);
    step(32'h20, 4'hF, 32'h1);
    check("raw_old", bus_if.rdata, 32'h0);
    step(32'h20, 4'h0, 32'h0);
    check("raw_new", bus_if.rdata, 32'h1);

    // Timer carry across halves; the write cycle does not increment
    step(MMIO_BASE, 4'hF, 32'hFFFF_FFFF);
    step(MMIO_BASE + 32'h4, 4'h0, 32'h0);
    check("carry_hi_before", bus_if.rdata, 32'h0);
    step(MMIO_BASE + 32'h4, 4'h0, 32'h0);
    check("carry_hi_after", bus_if.rdata, 32'h1);
    step(MMIO_BASE, 4'h0, 32'h0);
    check("carry_lo", bus_if.rdata, 32'h1);

    // Reserved MMIO slot: reads zero, writes raise no err
    step(MMIO_BASE + 32'hC, 4'hF, 32'hFFFF_FFFF);
    check("rsvd_err", 32'(bus_if.err), 32'h0);
    check("rsvd_rd", bus_if.rdata, 32'h0);

    // tohost: partial write with bit0 set must not halt
    step(MMIO_BASE + 32'h8, 4'b0001, 32'h0000_0001);
    check("tohost_part_halt", 32'(bus_if.halt), 32'h0);
    check("tohost_part_exit", 32'(bus_if.exit_code), 32'h0);
    step(MMIO_BASE + 32'h8, 4'hF, 32'h0000_0055);
    check("exit_halt", 32'(bus_if.halt), 32'h1);
    check("exit_code", 32'(bus_if.exit_code), 32'd42);
    step(MMIO_BASE + 32'h8, 4'h0, 32'h0);
    check("tohost_rd", bus_if.rdata, 32'h0000_0055);
    step(MMIO_BASE + 32'h8, 4'hF, 32'h0);
    check("halt_sticky", 32'(bus_if.halt), 32'h1);
    check("exit_cleared", 32'(bus_if.exit_code), 32'h0);

    // Unmapped writes: err pulses per cycle, RAM untouched, reads give zero
    step(32'h0, 4'hF, 32'h1234_5678);
    check("word0_err", 32'(bus_if.err), 32'h0);
    step(UNMAPPED, 4'hF, 32'hFFFF_FFFF);
    check("bad_wr_err", 32'(bus_if.err), 32'h1);
    check("bad_wr_rd", bus_if.rdata, 32'h0);
    step(UNMAPPED, 4'hF, 32'hFFFF_FFFF);
    check("bad_wr_err2", 32'(bus_if.err), 32'h1);
    step(UNMAPPED, 4'h0, 32'h0);
    check("bad_rd_err", 32'(bus_if.err), 32'h0);
    check("bad_rd_data", bus_if.rdata, 32'h0);
    step(32'h4000_0000, 4'h0, 32'h0);
    check("far_rd_err", 32'(bus_if.err), 32'h0);
    step(32'h0, 4'h0, 32'h0);
    check("word0_kept", bus_if.rdata, 32'h1234_5678);

    // Reset mid-operation: pending read dropped, state cleared, RAM kept
    rst = 1'b1;
    step(32'h10, 4'hF, 32'h0);
    check("mid_rst_rdata", bus_if.rdata, 32'h0);
    check("mid_rst_halt", 32'(bus_if.halt), 32'h0);
    check("mid_rst_exit", 32'(bus_if.exit_code), 32'h0);
    rst = 1'b0;
    step(MMIO_BASE, 4'h0, 32'h0);
    check("mid_rst_mtime", bus_if.rdata, 32'h0);
    step(32'h10, 4'h0, 32'h0);
    check("mid_rst_ram", bus_if.rdata, 32'hDEAD_55EF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
